// File: rtl/segment_execute.sv
// Execute stage: ARM condition check against an NZCV register, ALU, flag update and EX/MEM register.
// Define EXEC_MUL_EN to build the iterative shift-add multiplier (ALUControlE=111), which stalls upstream while busy.
module segment_execute #(
    parameter int MUL_STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        PCSrcE,
    input  logic        RegWriteE,
    input  logic        MemtoRegE,
    input  logic        MemWriteE,
    input  logic [2:0]  ALUControlE,
    input  logic        BranchE,
    input  logic        ALUSrcE,
    input  logic        FlagWriteE,
    input  logic [3:0]  condE,
    input  logic [3:0]  WA3E,
    input  logic [31:0] rd1E,
    input  logic [31:0] rd2E,
    input  logic [31:0] ExtImmE,
    output logic        PCSrcM,
    output logic        RegWriteM,
    output logic        MemtoRegM,
    output logic        MemWriteM,
    output logic [3:0]  WA3M,
    output logic [31:0] ALUResultM,
    output logic [31:0] WriteDataM,
    output logic [3:0]  FlagsO,
    output logic        stall_o
);
    localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_ORR = 3'b011;
    localparam logic [2:0] OP_EOR = 3'b100, OP_MOV = 3'b101, OP_CMP = 3'b110, OP_MUL = 3'b111;

    if (!(MUL_STEP == 1 || MUL_STEP == 2 || MUL_STEP == 4 || MUL_STEP == 8)) begin : g_bad_step
        $error("MUL_STEP must be 1, 2, 4 or 8");
    end

    logic [31:0] src_b, b_eff, alu_res;
    logic [32:0] sum;
    logic        is_sub, is_mul, alu_c, alu_v, cond_ex, issue_en;
    logic [3:0]  flags_q, flags_d;
    logic        pcsrc_q, pcsrc_d, regwrite_q, regwrite_d, memtoreg_q, memtoreg_d, memwrite_q, memwrite_d;
    logic [3:0]  wa3_q, wa3_d;
    logic [31:0] result_q, result_d, wdata_q, wdata_d;

    assign src_b  = ALUSrcE ? ExtImmE : rd2E;
    assign is_sub = (ALUControlE == OP_SUB) || (ALUControlE == OP_CMP);
    assign is_mul = (ALUControlE == OP_MUL);
    assign b_eff  = is_sub ? ~src_b : src_b;
    assign sum    = {1'b0, rd1E} + {1'b0, b_eff} + {32'd0, is_sub};

    // Condition is evaluated on the flags as they stand before this instruction writes them.
    always_comb begin
        case (condE)
            4'b0000: cond_ex = flags_q[2];
            4'b0001: cond_ex = ~flags_q[2];
            4'b0010: cond_ex = flags_q[1];
            4'b0011: cond_ex = ~flags_q[1];
            4'b0100: cond_ex = flags_q[3];
            4'b0101: cond_ex = ~flags_q[3];
            4'b0110: cond_ex = flags_q[0];
            4'b0111: cond_ex = ~flags_q[0];
            4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
            4'b1001: cond_ex = ~flags_q[1] | flags_q[2];
            4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
            4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
            4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
            4'b1101: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
            default: cond_ex = 1'b1;
        endcase
    end

    // Logic ops leave C and V at their current values.
    always_comb begin
        alu_res = 32'd0;
        alu_c   = flags_q[1];
        alu_v   = flags_q[0];
        case (ALUControlE)
            OP_ADD, OP_SUB, OP_CMP: begin
                alu_res = sum[31:0];
                alu_c   = sum[32];
                alu_v   = (rd1E[31] == b_eff[31]) && (sum[31] != rd1E[31]);
            end
            OP_AND:  alu_res = rd1E & src_b;
            OP_ORR:  alu_res = rd1E | src_b;
            OP_EOR:  alu_res = rd1E ^ src_b;
            OP_MOV:  alu_res = src_b;
            default: alu_res = 32'd0;
        endcase
    end

`ifdef EXEC_MUL_EN
    localparam int N = 32 / MUL_STEP;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t      state_q, state_d;
    logic        mul_req;
    logic [31:0] mul_a_q, mul_b_q, acc_q;
    logic [5:0]  cnt_q;
    logic        m_pc_q, m_rw_q, m_m2r_q, m_mw_q, m_fw_q;
    logic [3:0]  m_wa3_q;
    logic [31:0] m_wd_q;

    assign mul_req  = is_mul & cond_ex & ~flush_i;
    assign stall_o  = ((state_q == S_IDLE) & mul_req) | (state_q == S_RUN);
    assign issue_en = (state_q == S_IDLE) & ~flush_i & ~is_mul;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (mul_req) state_d = S_RUN;
            S_RUN:   if (flush_i) state_d = S_IDLE;
                     else if (cnt_q == 6'(N - 1)) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Multiplicand shifts left, multiplier shifts right; MUL_STEP bits retired per edge.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            mul_a_q <= '0; mul_b_q <= '0; acc_q <= '0; cnt_q <= '0;
            m_pc_q <= 1'b0; m_rw_q <= 1'b0; m_m2r_q <= 1'b0; m_mw_q <= 1'b0; m_fw_q <= 1'b0;
            m_wa3_q <= '0; m_wd_q <= '0;
        end else if (state_q == S_IDLE && mul_req) begin
            mul_a_q <= rd1E; mul_b_q <= src_b; acc_q <= '0; cnt_q <= '0;
            m_pc_q <= PCSrcE | BranchE; m_rw_q <= RegWriteE; m_m2r_q <= MemtoRegE;
            m_mw_q <= MemWriteE; m_fw_q <= FlagWriteE; m_wa3_q <= WA3E; m_wd_q <= rd2E;
        end else if (state_q == S_RUN) begin
            acc_q   <= acc_q + mul_a_q * {{(32 - MUL_STEP){1'b0}}, mul_b_q[MUL_STEP-1:0]};
            mul_a_q <= mul_a_q << MUL_STEP;
            mul_b_q <= mul_b_q >> MUL_STEP;
            cnt_q   <= cnt_q + 6'd1;
        end
    end
`else
    assign stall_o  = 1'b0;
    assign issue_en = ~flush_i & ~is_mul;
`endif

    always_comb begin
        pcsrc_d = 1'b0; regwrite_d = 1'b0; memtoreg_d = 1'b0; memwrite_d = 1'b0;
        wa3_d = '0; result_d = '0; wdata_d = '0; flags_d = flags_q;
        if (issue_en) begin
            pcsrc_d    = (PCSrcE | BranchE) & cond_ex;
            regwrite_d = RegWriteE & cond_ex;
            memtoreg_d = MemtoRegE;
            memwrite_d = MemWriteE & cond_ex;
            wa3_d      = WA3E;
            result_d   = alu_res;
            wdata_d    = rd2E;
            if (FlagWriteE & cond_ex) flags_d = {alu_res[31], alu_res == 32'd0, alu_c, alu_v};
        end
`ifdef EXEC_MUL_EN
        else if (state_q == S_DONE && !flush_i) begin
            pcsrc_d = m_pc_q; regwrite_d = m_rw_q; memtoreg_d = m_m2r_q; memwrite_d = m_mw_q;
            wa3_d = m_wa3_q; result_d = acc_q; wdata_d = m_wd_q;
            if (m_fw_q) flags_d = {acc_q[31], acc_q == 32'd0, flags_q[1:0]};
        end
`endif
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            pcsrc_q <= 1'b0; regwrite_q <= 1'b0; memtoreg_q <= 1'b0; memwrite_q <= 1'b0;
            wa3_q <= '0; result_q <= '0; wdata_q <= '0; flags_q <= '0;
        end else begin
            pcsrc_q <= pcsrc_d; regwrite_q <= regwrite_d; memtoreg_q <= memtoreg_d;
            memwrite_q <= memwrite_d; wa3_q <= wa3_d; result_q <= result_d;
            wdata_q <= wdata_d; flags_q <= flags_d;
        end
    end

    assign PCSrcM     = pcsrc_q;
    assign RegWriteM  = regwrite_q;
    assign MemtoRegM  = memtoreg_q;
    assign MemWriteM  = memwrite_q;
    assign WA3M       = wa3_q;
    assign ALUResultM = result_q;
    assign WriteDataM = wdata_q;
    assign FlagsO     = flags_q;
endmodule

// File: tb/tb_segment_execute.sv
// Directed bench for segment_execute: a vector table for single-edge ALU/condition behaviour,
// plus hand sequences for multiply occupancy, flush and reset (both with and without EXEC_MUL_EN).
module tb_segment_execute;
    logic        clk, rst, flush_i, PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, FlagWriteE;
    logic [2:0]  ALUControlE;
    logic [3:0]  condE, WA3E;
    logic [31:0] rd1E, rd2E, ExtImmE;
    logic        PCSrcM, RegWriteM, MemtoRegM, MemWriteM, stall_o;
    logic [3:0]  WA3M, FlagsO;
    logic [31:0] ALUResultM, WriteDataM;

    int n_vec = 0;
    int n_miss = 0;
    logic [3:0] exp_flags;

    segment_execute #(.MUL_STEP(1)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .PCSrcE(PCSrcE), .RegWriteE(RegWriteE),
        .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE), .ALUControlE(ALUControlE), .BranchE(BranchE),
        .ALUSrcE(ALUSrcE), .FlagWriteE(FlagWriteE), .condE(condE), .WA3E(WA3E), .rd1E(rd1E),
        .rd2E(rd2E), .ExtImmE(ExtImmE), .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .MemWriteM(MemWriteM), .WA3M(WA3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .FlagsO(FlagsO), .stall_o(stall_o)
    );

    // Clock and reset: state changes on the falling edge.
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [2:0]  alu;
        logic [31:0] a, b, imm;
        logic        src, fw;
        logic [3:0]  cond;
        logic [4:0]  ctl;     // {pc, br, rw, m2r, mw}
        logic [3:0]  wa3;
        logic        fl;
        logic [31:0] e_res;
        logic [3:0]  e_ctl;   // {PCSrcM, RegWriteM, MemtoRegM, MemWriteM}
        logic [3:0]  e_wa3;
        logic [31:0] e_wd;
        logic [3:0]  e_flags;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] alu, input logic [31:0] a, b, imm,
                                input logic src, fw, input logic [3:0] cond, input logic [4:0] ctl,
                                input logic [3:0] wa3, input logic fl, input logic [31:0] e_res,
                                input logic [3:0] e_ctl, input logic [3:0] e_wa3,
                                input logic [31:0] e_wd, input logic [3:0] e_flags);
        vec_t v;
        v.alu = alu; v.a = a; v.b = b; v.imm = imm; v.src = src; v.fw = fw; v.cond = cond;
        v.ctl = ctl; v.wa3 = wa3; v.fl = fl; v.e_res = e_res; v.e_ctl = e_ctl; v.e_wa3 = e_wa3;
        v.e_wd = e_wd; v.e_flags = e_flags;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ALUControlE = v.alu; rd1E = v.a; rd2E = v.b; ExtImmE = v.imm; ALUSrcE = v.src;
        FlagWriteE = v.fw; condE = v.cond; {PCSrcE, BranchE, RegWriteE, MemtoRegE, MemWriteE} = v.ctl;
        WA3E = v.wa3; flush_i = v.fl;
    endtask

    task automatic drive_op(input logic [2:0] alu, input logic [31:0] a, b, input logic fw, rw,
                            input logic [3:0] wa3);
        drive(mk(alu, a, b, 32'd0, 1'b0, fw, 4'b1110, {2'b00, rw, 2'b00}, wa3, 1'b0,
                 32'd0, 4'd0, 4'd0, 32'd0, 4'd0));
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic chk_bubble(input string name);
        chk({name, "_ctl"}, {28'd0, PCSrcM, RegWriteM, MemtoRegM, MemWriteM}, 32'd0);
        chk({name, "_res"}, ALUResultM, 32'd0);
        chk({name, "_flags"}, {28'd0, FlagsO}, {28'd0, exp_flags});
    endtask

    vec_t vecs[15];

    initial begin
        vecs[0]  = mk(3'b001, 32'd5, 32'd5, 32'd0, 0, 1, 4'b1110, 5'b00100, 4'd3, 0,
                      32'd0, 4'b0100, 4'd3, 32'd5, 4'b0110);
        vecs[1]  = mk(3'b000, 32'd1, 32'd2, 32'd0, 0, 0, 4'b0001, 5'b00100, 4'd4, 0,
                      32'd3, 4'b0000, 4'd4, 32'd2, 4'b0110);
        vecs[2]  = mk(3'b000, 32'd1, 32'd2, 32'd0, 0, 0, 4'b0000, 5'b00100, 4'd4, 0,
                      32'd3, 4'b0100, 4'd4, 32'd2, 4'b0110);
        vecs[3]  = mk(3'b000, 32'h7FFFFFFF, 32'hAA, 32'd1, 1, 1, 4'b1110, 5'b00000, 4'd5, 0,
                      32'h80000000, 4'b0000, 4'd5, 32'hAA, 4'b1001);
        vecs[4]  = mk(3'b011, 32'hF0, 32'h0F, 32'd0, 0, 1, 4'b1010, 5'b00001, 4'd6, 0,
                      32'hFF, 4'b0001, 4'd6, 32'h0F, 4'b0001);
        vecs[5]  = mk(3'b010, 32'hF0, 32'h0F, 32'd0, 0, 1, 4'b0110, 5'b00000, 4'd1, 0,
                      32'd0, 4'b0000, 4'd1, 32'h0F, 4'b0101);
        vecs[6]  = mk(3'b100, 32'hFFFF0000, 32'h0000FFFF, 32'd0, 0, 0, 4'b1011, 5'b01000, 4'd2, 0,
                      32'hFFFFFFFF, 4'b1000, 4'd2, 32'h0000FFFF, 4'b0101);
        vecs[7]  = mk(3'b110, 32'd3, 32'd5, 32'd0, 0, 1, 4'b1110, 5'b00000, 4'd0, 0,
                      32'hFFFFFFFE, 4'b0000, 4'd0, 32'd5, 4'b1000);
        vecs[8]  = mk(3'b101, 32'h12345678, 32'h99, 32'd0, 1, 1, 4'b0100, 5'b00110, 4'd8, 0,
                      32'd0, 4'b0110, 4'd8, 32'h99, 4'b0100);
        vecs[9]  = mk(3'b000, 32'd1, 32'd1, 32'd0, 0, 1, 4'b1110, 5'b10101, 4'd9, 1,
                      32'd0, 4'b0000, 4'd0, 32'd0, 4'b0100);
        vecs[10] = mk(3'b001, 32'h80000000, 32'd1, 32'd0, 0, 1, 4'b0010, 5'b00100, 4'hA, 0,
                      32'h7FFFFFFF, 4'b0000, 4'hA, 32'd1, 4'b0100);
        vecs[11] = mk(3'b001, 32'h80000000, 32'd1, 32'd0, 0, 1, 4'b1110, 5'b00100, 4'hA, 0,
                      32'h7FFFFFFF, 4'b0100, 4'hA, 32'd1, 4'b0011);
        vecs[12] = mk(3'b000, 32'hFFFFFFFF, 32'd1, 32'd0, 0, 1, 4'b1000, 5'b10000, 4'hB, 0,
                      32'd0, 4'b1000, 4'hB, 32'd1, 4'b0110);
        vecs[13] = mk(3'b000, 32'd2, 32'd3, 32'd0, 0, 0, 4'b1101, 5'b00100, 4'hC, 0,
                      32'd5, 4'b0100, 4'hC, 32'd3, 4'b0110);
        vecs[14] = mk(3'b000, 32'd10, 32'd20, 32'd0, 0, 0, 4'b1100, 5'b10111, 4'hD, 0,
                      32'd30, 4'b0010, 4'hD, 32'd20, 4'b0110);

        rst = 1'b1;
        drive_op(3'b000, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0);
        #3;
        chk("reset_ctl", {28'd0, PCSrcM, RegWriteM, MemtoRegM, MemWriteM}, 32'd0);
        chk("reset_res", ALUResultM, 32'd0);
        chk("reset_flags", {28'd0, FlagsO}, 32'd0);
        chk("reset_stall", {31'd0, stall_o}, 32'd0);
        #9 rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i]);
            tick();
            chk($sformatf("v%0d_res", i), ALUResultM, vecs[i].e_res);
            chk($sformatf("v%0d_ctl", i), {28'd0, PCSrcM, RegWriteM, MemtoRegM, MemWriteM},
                {28'd0, vecs[i].e_ctl});
            chk($sformatf("v%0d_wa3", i), {28'd0, WA3M}, {28'd0, vecs[i].e_wa3});
            chk($sformatf("v%0d_wd", i), WriteDataM, vecs[i].e_wd);
            chk($sformatf("v%0d_flags", i), {28'd0, FlagsO}, {28'd0, vecs[i].e_flags});
            chk($sformatf("v%0d_stall", i), {31'd0, stall_o}, 32'd0);
        end
        exp_flags = 4'b0110;

`ifdef EXEC_MUL_EN
        // 0x10001 squared: 33 stalled cycles, result on the 34th edge.
        drive_op(3'b111, 32'h10001, 32'h10001, 1'b1, 1'b1, 4'd7);
        #1 chk("mul_stall_start", {31'd0, stall_o}, 32'd1);
        for (int k = 1; k <= 33; k++) begin
            tick();
            chk($sformatf("mul_stall_e%0d", k), {31'd0, stall_o}, (k <= 32) ? 32'd1 : 32'd0);
            chk($sformatf("mul_bubble_e%0d", k), {31'd0, RegWriteM}, 32'd0);
            chk($sformatf("mul_bubres_e%0d", k), ALUResultM, 32'd0);
        end
        tick();
        exp_flags = 4'b0010;
        chk("mul_res", ALUResultM, 32'h00020001);
        chk("mul_rw", {31'd0, RegWriteM}, 32'd1);
        chk("mul_wa3", {28'd0, WA3M}, 32'd7);
        chk("mul_wd", WriteDataM, 32'h10001);
        chk("mul_flags", {28'd0, FlagsO}, {28'd0, exp_flags});
        drive_op(3'b000, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0);
        #1 chk("mul_stall_after", {31'd0, stall_o}, 32'd0);

        // Flush in the middle of a multiply.
        drive_op(3'b111, 32'd3, 32'd4, 1'b1, 1'b1, 4'd2);
        for (int k = 0; k < 5; k++) tick();
        flush_i = 1'b1;
        #1 chk("flush_stall_run", {31'd0, stall_o}, 32'd1);
        tick();
        chk("flush_stall_drop", {31'd0, stall_o}, 32'd0);
        chk_bubble("flush_mul");
        drive_op(3'b000, 32'd6, 32'd1, 1'b0, 1'b1, 4'd1);
        tick();
        chk("flush_next_res", ALUResultM, 32'd7);
        chk("flush_next_flags", {28'd0, FlagsO}, {28'd0, exp_flags});
        for (int k = 0; k < 40; k++) begin
            tick();
            if (k == 39) chk("flush_no_late_mul", ALUResultM, 32'd7);
        end

        // Reset pulse while the multiplier runs.
        drive_op(3'b111, 32'd9, 32'd9, 1'b1, 1'b1, 4'd3);
        for (int k = 0; k < 3; k++) tick();
`else
        // Without the multiplier, MUL is a bubble and never stalls.
        drive_op(3'b111, 32'h10001, 32'h10001, 1'b1, 1'b1, 4'd7);
        #1 chk("mul_off_stall", {31'd0, stall_o}, 32'd0);
        tick();
        chk_bubble("mul_off");
        chk("mul_off_wa3", {28'd0, WA3M}, 32'd0);
        drive_op(3'b000, 32'd6, 32'd1, 1'b0, 1'b1, 4'd1);
        tick();
        chk("mul_off_next_res", ALUResultM, 32'd7);
`endif
        #2 rst = 1'b1;
        drive_op(3'b000, 32'd2, 32'd3, 1'b0, 1'b1, 4'd4);
        exp_flags = 4'b0000;
        #1;
        chk_bubble("rst_mid");
        chk("rst_mid_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_mid_wa3", {28'd0, WA3M}, 32'd0);
        #2 rst = 1'b0;
        tick();
        chk("rst_add_res", ALUResultM, 32'd5);
        chk("rst_add_rw", {31'd0, RegWriteM}, 32'd1);
        chk("rst_add_stall", {31'd0, stall_o}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
